// File: rtl/chaos_ctrl_pkg.sv
// chaos_ctrl_pkg: shared state encoding and timing defaults for the chaos iteration controller
package chaos_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, ARM, ISSUE, WAIT_VALID, GAP, DONE, ERR} state_t;
  localparam int PULSE_W_DEF = 2;
  localparam int TIMEOUT_DEF = 1023;
  localparam int TMR_W = 16;
endpackage

// File: rtl/chaos_timeout_cnt.sv
// chaos_timeout_cnt: loadable down-counter whose expire flags the last cycle of a loaded interval
module chaos_timeout_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : load ? load_val : (cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
  assign expire = cnt_q == W'(1);
endmodule

// File: rtl/chaos_iter_ctrl.sv
// chaos_iter_ctrl: sequences calcu_ctrl iterations of a chaotic core in burst or continuous runs
module chaos_iter_ctrl
  import chaos_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int PULSE_W = PULSE_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cont_mode,
  input  logic [CNT_W-1:0] iter_num,
  input  logic [7:0]       gap_cycles,
  input  logic             busy,
  input  logic             n1_valid,
  output logic             calcu_ctrl,
  output logic             pair_vld,
  output logic [CNT_W-1:0] iter_cnt,
  output logic             running,
  output logic             done,
  output logic             err_timeout,
  output logic             err_spurious
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d, iter_num_q, iter_num_d, cnt_inc;
  logic [7:0] gap_q, gap_d;
  logic cont_q, cont_d, phase_q, phase_d, busy_q;
  logic calcu_ctrl_q, pair_vld_q, pair_vld_d, running_q, done_q, done_d;
  logic err_to_q, err_to_d, err_sp_q, err_sp_d;
  logic pg_load, pg_clr, pg_exp, to_load, to_clr, to_exp;
  logic [TMR_W-1:0] pg_val;
  assign cnt_inc = iter_cnt_q + CNT_W'(1);
  always_comb begin
    state_d = state_q;
    iter_cnt_d = iter_cnt_q;
    iter_num_d = iter_num_q;
    gap_d = gap_q;
    cont_d = cont_q;
    phase_d = phase_q;
    pair_vld_d = 1'b0;
    done_d = 1'b0;
    err_to_d = err_to_q;
    err_sp_d = err_sp_q;
    pg_load = 1'b0;
    pg_val = '0;
    to_load = 1'b0;
    if (abort) state_d = IDLE;
    else
      case (state_q)
        IDLE, DONE, ERR: begin
          err_sp_d = err_sp_q | n1_valid;
          if (start) begin
            cont_d = cont_mode;
            iter_num_d = iter_num;
            gap_d = gap_cycles;
            iter_cnt_d = '0;
            phase_d = 1'b0;
            err_to_d = 1'b0;
            err_sp_d = 1'b0;
            done_d = !cont_mode && iter_num == '0;
            state_d = done_d ? DONE : ARM;
          end
        end
        ARM: begin
          err_sp_d = err_sp_q | n1_valid;
          if (!busy_q) begin
            state_d = ISSUE;
            pg_load = 1'b1;
            pg_val = TMR_W'(PULSE_W);
            to_load = 1'b1;
          end
        end
        ISSUE, WAIT_VALID: begin
          if (n1_valid) begin
            iter_cnt_d = cnt_inc;
            phase_d = !phase_q;
            pair_vld_d = phase_q;
            done_d = !cont_q && cnt_inc == iter_num_q;
            state_d = done_d ? DONE : gap_q == '0 ? ARM : GAP;
            pg_load = state_d == GAP;
            pg_val = TMR_W'(gap_q);
          end else if (to_exp) begin
            state_d = ERR;
            err_to_d = 1'b1;
          end else if (state_q == ISSUE && pg_exp) state_d = WAIT_VALID;
        end
        GAP: begin
          err_sp_d = err_sp_q | n1_valid;
          if (pg_exp) state_d = ARM;
        end
        default: state_d = IDLE;
      endcase
  end
  assign pg_clr = !(state_d inside {ISSUE, GAP});
  assign to_clr = !(state_d inside {ISSUE, WAIT_VALID});
  chaos_timeout_cnt #(.W(TMR_W)) u_pg_tmr (
    .clk(clk), .rst_n(rst_n), .clr(pg_clr), .load(pg_load), .load_val(pg_val), .expire(pg_exp)
  );
  chaos_timeout_cnt #(.W(TMR_W)) u_to_tmr (
    .clk(clk), .rst_n(rst_n), .clr(to_clr), .load(to_load), .load_val(TMR_W'(TIMEOUT)), .expire(to_exp)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      iter_cnt_q <= '0;
      iter_num_q <= '0;
      gap_q <= '0;
      cont_q <= 1'b0;
      phase_q <= 1'b0;
      busy_q <= 1'b1;
      calcu_ctrl_q <= 1'b0;
      pair_vld_q <= 1'b0;
      running_q <= 1'b0;
      done_q <= 1'b0;
      err_to_q <= 1'b0;
      err_sp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_cnt_q <= iter_cnt_d;
      iter_num_q <= iter_num_d;
      gap_q <= gap_d;
      cont_q <= cont_d;
      phase_q <= phase_d;
      busy_q <= busy;
      calcu_ctrl_q <= state_d == ISSUE;
      pair_vld_q <= pair_vld_d;
      running_q <= !(state_d inside {IDLE, DONE, ERR});
      done_q <= done_d;
      err_to_q <= err_to_d;
      err_sp_q <= err_sp_d;
    end
  assign calcu_ctrl = calcu_ctrl_q;
  assign pair_vld = pair_vld_q;
  assign iter_cnt = iter_cnt_q;
  assign running = running_q;
  assign done = done_q;
  assign err_timeout = err_to_q;
  assign err_spurious = err_sp_q;
endmodule
